// File: rtl/occ_pkg.sv
// ============================================================================
// occ_pkg: shared geometry, colour codes and FSM encoding for the occupancy map
// Rev 1.0
// ============================================================================
`default_nettype none

package occ_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int COLOUR_W = 3;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int ADDR_W   = 15;
  localparam int DEPTH    = SCREEN_W * SCREEN_H;

  localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_H - 1);

  localparam logic [COLOUR_W-1:0] COL_EMPTY   = 3'b000;
  localparam logic [COLOUR_W-1:0] COL_SNAKE_A = 3'b001;
  localparam logic [COLOUR_W-1:0] COL_SNAKE_B = 3'b100;
  localparam logic [COLOUR_W-1:0] COL_WALL    = 3'b111;

  localparam logic [X_W-1:0] BORDER_X_LO = 8'd10;
  localparam logic [X_W-1:0] BORDER_X_HI = 8'd149;
  localparam logic [Y_W-1:0] BORDER_Y_LO = 7'd17;
  localparam logic [Y_W-1:0] BORDER_Y_HI = 7'd108;

  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic                mark;
    logic [COLOUR_W-1:0] colour;
  } occ_req_t;

  // y*160 + x as two shifts and adds, so no multiplier is inferred
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [X_W-1:0] x,
                                                 input logic [Y_W-1:0] y);
    logic [ADDR_W-1:0] yw;
    yw = {{(ADDR_W-Y_W){1'b0}}, y};
    return (yw << 7) + (yw << 5) + {{(ADDR_W-X_W){1'b0}}, x};
  endfunction

  function automatic logic in_range(input logic [X_W-1:0] x,
                                    input logic [Y_W-1:0] y);
    return (x <= X_LAST) && (y <= Y_LAST);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pixel_occupancy_reader_if.sv
// ============================================================================
// pixel_occupancy_reader_if: query request / response bus of the occupancy map
// Rev 1.0
// ============================================================================
`default_nettype none

interface pixel_occupancy_reader_if;
  import occ_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic [X_W-1:0]      req_x;
  logic [Y_W-1:0]      req_y;
  logic                req_mark;
  logic [COLOUR_W-1:0] req_colour;
  logic                rsp_valid;
  logic                rsp_hit;
  logic [COLOUR_W-1:0] rsp_colour;

  modport master (
    output req_valid, req_x, req_y, req_mark, req_colour,
    input  req_ready, rsp_valid, rsp_hit, rsp_colour
  );

  modport slave (
    input  req_valid, req_x, req_y, req_mark, req_colour,
    output req_ready, rsp_valid, rsp_hit, rsp_colour
  );

endinterface

`default_nettype wire

// File: rtl/occ_ram.sv
// ============================================================================
// occ_ram: single-port synchronous RAM with registered read (block-RAM style)
// Rev 1.0
// ============================================================================
`default_nettype none

module occ_ram #(
  parameter int DEPTH  = 19200,
  parameter int ADDR_W = 15,
  parameter int DATA_W = 3
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Read-before-write: rdata returns the old contents on a write cycle
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/pixel_occupancy_reader.sv
// ============================================================================
// pixel_occupancy_reader: shadow occupancy map answering "colour at (x,y)?"
// Optional OCC_BORDER_EN: the clear sweep paints the arena border as wall.
// Rev 1.0
// ============================================================================
`default_nettype none

module pixel_occupancy_reader
  import occ_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  output logic                     busy,
  pixel_occupancy_reader_if.slave  bus
);

  logic [1:0]          state_q, state_d;
  logic [X_W-1:0]      sx_q, sx_d;
  logic [Y_W-1:0]      sy_q, sy_d;
  occ_req_t            req_q, req_d;
  logic                oor_q, oor_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_hit_q, rsp_hit_d;
  logic [COLOUR_W-1:0] rsp_colour_q, rsp_colour_d;

  logic                ram_en, ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [COLOUR_W-1:0] ram_wdata, ram_rdata, sweep_colour;

`ifdef OCC_BORDER_EN
  assign sweep_colour = (sx_q == BORDER_X_LO || sx_q == BORDER_X_HI ||
                         sy_q == BORDER_Y_LO || sy_q == BORDER_Y_HI) ? COL_WALL : COL_EMPTY;
`else
  assign sweep_colour = COL_EMPTY;
`endif

  always_comb begin
    state_d       = state_q;
    sx_d          = sx_q;
    sy_d          = sy_q;
    req_d         = req_q;
    oor_d         = oor_q;
    rsp_valid_d   = 1'b0;
    rsp_hit_d     = rsp_hit_q;
    rsp_colour_d  = rsp_colour_q;
    ram_en        = 1'b0;
    ram_we        = 1'b0;
    ram_addr      = pix_addr(req_q.x, req_q.y);
    ram_wdata     = req_q.colour;
    bus.req_ready = 1'b0;

    case (state_q)
      S_CLEAR: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = pix_addr(sx_q, sy_q);
        ram_wdata = sweep_colour;
        if (sx_q == X_LAST) begin
          sx_d = '0;
          sy_d = sy_q + 7'd1;
        end else begin
          sx_d = sx_q + 8'd1;
        end
        if (sx_q == X_LAST && sy_q == Y_LAST) begin
          sy_d    = '0;
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        bus.req_ready = !clear;
        if (bus.req_valid && !clear) begin
          req_d.x      = bus.req_x;
          req_d.y      = bus.req_y;
          req_d.mark   = bus.req_mark;
          req_d.colour = bus.req_colour;
          oor_d        = !in_range(bus.req_x, bus.req_y);
          state_d      = S_READ;
        end
      end
      S_READ: begin
        ram_en  = !oor_q;
        state_d = S_RESP;
      end
      S_RESP: begin
        ram_en       = req_q.mark && !oor_q;
        ram_we       = req_q.mark && !oor_q;
        rsp_valid_d  = 1'b1;
        rsp_hit_d    = oor_q || (ram_rdata != COL_EMPTY);
        rsp_colour_d = oor_q ? COL_WALL : ram_rdata;
        state_d      = S_IDLE;
      end
      default: state_d = S_CLEAR;
    endcase

    // Clear overrides everything: drop in-flight work and restart the sweep
    if (clear) begin
      state_d      = S_CLEAR;
      sx_d         = '0;
      sy_d         = '0;
      rsp_valid_d  = 1'b0;
      rsp_hit_d    = rsp_hit_q;
      rsp_colour_d = rsp_colour_q;
      ram_en       = 1'b0;
      ram_we       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_CLEAR;
      sx_q         <= '0;
      sy_q         <= '0;
      req_q        <= '0;
      oor_q        <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_hit_q    <= 1'b0;
      rsp_colour_q <= COL_EMPTY;
    end else begin
      state_q      <= state_d;
      sx_q         <= sx_d;
      sy_q         <= sy_d;
      req_q        <= req_d;
      oor_q        <= oor_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_hit_q    <= rsp_hit_d;
      rsp_colour_q <= rsp_colour_d;
    end
  end

  occ_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (COLOUR_W)
  ) u_ram (
    .clk     (clk),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  assign busy           = (state_q == S_CLEAR);
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_hit    = rsp_hit_q;
  assign bus.rsp_colour = rsp_colour_q;

endmodule

`default_nettype wire

// File: tb/tb_pixel_occupancy_reader.sv
// ============================================================================
// tb_pixel_occupancy_reader: scoreboard bench with directed queries
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pixel_occupancy_reader;
  import occ_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic clear;
  logic busy;

  pixel_occupancy_reader_if bus();

  pixel_occupancy_reader dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .busy  (busy),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       hit;
    logic [2:0] col;
    int         cyc;
    int         tag;
  } exp_t;

  exp_t       q[$];
  int         total = 0;
  int         bad   = 0;
  logic       last_hit = 1'b0;
  logic [2:0] last_col = 3'b000;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  // Monitor: every response strobe must match the oldest expectation
  always @(negedge clk) begin
    if (bus.rsp_valid === 1'b1) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_rsp: got rsp_valid at cycle %0d want none", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        last_hit = e.hit;
        last_col = e.col;
        if (bus.rsp_hit !== e.hit || bus.rsp_colour !== e.col || cyc != e.cyc) begin
          bad++;
          $display("FAIL rsp_%0d: got hit=%b col=%b cyc=%0d want hit=%b col=%b cyc=%0d",
                   e.tag, bus.rsp_hit, bus.rsp_colour, cyc, e.hit, e.col, e.cyc);
        end
      end
    end
  end

  // Drive one request; returns at the negedge after acceptance (READ cycle)
  task automatic issue(input int tag, input logic [7:0] x, input logic [6:0] y,
                       input logic mark, input logic [2:0] col, input logic push,
                       input logic eh, input logic [2:0] ec);
    int n = 0;
    bit done = 0;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_x      = x;
    bus.req_y      = y;
    bus.req_mark   = mark;
    bus.req_colour = col;
    while (!done) begin
      if (bus.req_ready === 1'b1) begin
        if (push) q.push_back('{eh, ec, cyc + 3, tag});
        @(negedge clk);
        done = 1;
      end else if (n > 30000) begin
        check("accept_timeout", n, 0);
        done = 1;
      end else begin
        n++;
        @(negedge clk);
      end
    end
    bus.req_valid  = 1'b0;
    bus.req_x      = ~x;
    bus.req_y      = ~y;
    bus.req_mark   = ~mark;
    bus.req_colour = ~col;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("drain_pending", q.size(), 0);
    @(negedge clk);
    check("hold_valid", int'(bus.rsp_valid), 0);
    check("hold_hit", int'(bus.rsp_hit), int'(last_hit));
    check("hold_col", int'(bus.rsp_colour), int'(last_col));
  endtask

  task automatic wait_sweep(input string name);
    int n = 0;
    while (busy === 1'b1 && n < 25000) begin
      n++;
      @(negedge clk);
    end
    check(name, n, DEPTH);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset          = 1'b1;
    clear          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_x      = '0;
    bus.req_y      = '0;
    bus.req_mark   = 1'b0;
    bus.req_colour = '0;

    @(negedge clk);
    reset = 1'b0;
    check("reset_rsp_valid", int'(bus.rsp_valid), 0);
    check("reset_rsp_hit", int'(bus.rsp_hit), 0);
    check("reset_rsp_col", int'(bus.rsp_colour), 0);
    check("reset_ready", int'(bus.req_ready), 0);
    check("reset_busy", int'(busy), 1);
    wait_sweep("sweep_after_reset");
    check("ready_after_sweep", int'(bus.req_ready), 1);

    // Mark then re-read, back to back
    issue(1, 8'd25, 7'd100, 1'b1, COL_SNAKE_A, 1'b1, 1'b0, 3'b000);
    issue(2, 8'd25, 7'd100, 1'b0, 3'b000, 1'b1, 1'b1, 3'b001);
    // Out of range never writes, even with mark
    issue(3, 8'd160, 7'd5, 1'b1, COL_SNAKE_B, 1'b1, 1'b1, 3'b111);
    issue(4, 8'd0, 7'd5, 1'b0, 3'b000, 1'b1, 1'b0, 3'b000);
    issue(5, 8'd0, 7'd6, 1'b0, 3'b000, 1'b1, 1'b0, 3'b000);
    issue(6, 8'd25, 7'd120, 1'b1, COL_SNAKE_B, 1'b1, 1'b1, 3'b111);
    issue(7, 8'd255, 7'd127, 1'b0, 3'b000, 1'b1, 1'b1, 3'b111);
    issue(8, 8'd159, 7'd119, 1'b1, COL_SNAKE_B, 1'b1, 1'b0, 3'b000);
    issue(9, 8'd159, 7'd119, 1'b0, 3'b000, 1'b1, 1'b1, 3'b100);
`ifdef OCC_BORDER_EN
    issue(10, 8'd10, 7'd50, 1'b0, 3'b000, 1'b1, 1'b1, 3'b111);
    issue(11, 8'd11, 7'd50, 1'b0, 3'b000, 1'b1, 1'b0, 3'b000);
    issue(12, 8'd60, 7'd108, 1'b0, 3'b000, 1'b1, 1'b1, 3'b111);
`else
    issue(10, 8'd10, 7'd50, 1'b0, 3'b000, 1'b1, 1'b0, 3'b000);
    issue(11, 8'd60, 7'd108, 1'b0, 3'b000, 1'b1, 1'b0, 3'b000);
`endif
    drain();

    // Clear during READ aborts the transaction and wipes the map
    issue(20, 8'd135, 7'd100, 1'b1, COL_SNAKE_B, 1'b1, 1'b0, 3'b000);
    drain();
    issue(21, 8'd5, 7'd5, 1'b1, COL_SNAKE_A, 1'b0, 1'b0, 3'b000);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_read_busy", int'(busy), 1);
    wait_sweep("sweep_after_clear_read");
    issue(22, 8'd135, 7'd100, 1'b0, 3'b000, 1'b1, 1'b0, 3'b000);
    issue(23, 8'd5, 7'd5, 1'b0, 3'b000, 1'b1, 1'b0, 3'b000);
    drain();

    // Clear and req_valid together in IDLE: clear wins
    @(negedge clk);
    clear          = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_x      = 8'd0;
    bus.req_y      = 7'd0;
    bus.req_mark   = 1'b1;
    bus.req_colour = COL_SNAKE_A;
    #1;
    check("clear_blocks_ready", int'(bus.req_ready), 0);
    @(negedge clk);
    clear         = 1'b0;
    bus.req_valid = 1'b0;
    check("clear_idle_busy", int'(busy), 1);
    wait_sweep("sweep_after_clear_idle");
    issue(30, 8'd0, 7'd0, 1'b0, 3'b000, 1'b1, 1'b0, 3'b000);
    drain();

    // Reset in the middle of a marking transaction
    issue(40, 8'd40, 7'd40, 1'b1, COL_SNAKE_B, 1'b0, 1'b0, 3'b000);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    last_hit = 1'b0;
    last_col = 3'b000;
    check("midreset_busy", int'(busy), 1);
    check("midreset_rsp_hit", int'(bus.rsp_hit), 0);
    check("midreset_rsp_col", int'(bus.rsp_colour), 0);
    wait_sweep("sweep_after_midreset");
    issue(41, 8'd40, 7'd40, 1'b0, 3'b000, 1'b1, 1'b0, 3'b000);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
